// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter and the core memory stage.
// Contents: FSM state enum, read-owner tag encoding, default address/data widths.
package dmem_pkg;

    localparam int unsigned DMEM_AW = 10;
    localparam int unsigned DMEM_DW = 32;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_EXT  = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// Modports:
//   slave  - arbiter side: takes requests and m_rdata, drives grants, read returns,
//            memory controls and core_stall.
//   master - environment side (core LSU, external port, memory): the mirror image.
interface dmem_arbiter_if
    import dmem_pkg::*;
#(
    parameter int unsigned AW = DMEM_AW,
    parameter int unsigned DW = DMEM_DW
);
    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic          c_gnt;
    logic          c_rvalid;
    logic [DW-1:0] c_rdata;

    logic          x_req;
    logic          x_we;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_wdata;
    logic          x_gnt;
    logic          x_rvalid;
    logic [DW-1:0] x_rdata;
    logic          x_lock;

    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    logic          core_stall;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        input  x_req, x_we, x_addr, x_wdata, x_lock,
        input  m_rdata,
        output c_gnt, c_rvalid, c_rdata,
        output x_gnt, x_rvalid, x_rdata,
        output m_en, m_we, m_addr, m_wdata,
        output core_stall
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        output x_req, x_we, x_addr, x_wdata, x_lock,
        output m_rdata,
        input  c_gnt, c_rvalid, c_rdata,
        input  x_gnt, x_rvalid, x_rdata,
        input  m_en, m_we, m_addr, m_wdata,
        input  core_stall
    );

endinterface

// File: rtl/starve_counter.sv
// Saturating counter with clear priority over increment; stops at LIMIT.
// Ports: clk, reset (sync, active-high), clr_i, inc_i, cnt_o (registered count).
module starve_counter #(
    parameter int unsigned W     = 3,
    parameter int unsigned LIMIT = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise increment until LIMIT
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != W'(LIMIT))) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory (core LSU vs external
// loader/debug port), with read-return routing and an external lock mode.
// Ports: clk, reset (sync, active-high), bus (dmem_arbiter_if.slave).
// Grants and memory drive are combinational in the request cycle; read returns
// follow one cycle after a read grant.
// Build option: DMEM_ARB_STARVE_GUARD_EN adds the external starvation guard.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned AW           = DMEM_AW,
    parameter int unsigned DW           = DMEM_DW,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);

    arb_state_e    state_q, state_d;
    logic          c_gnt_c, x_gnt_c;
    logic          force_x_c;
    logic          m_we_c;
    logic [AW-1:0] m_addr_c;
    logic [DW-1:0] m_wdata_c;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_owner_q, rd_owner_d;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam int unsigned SCW = $clog2(STARVE_LIMIT + 1);

    logic           contested_c;
    logic           starve_inc_c;
    logic [SCW-1:0] starve_cnt;

    assign contested_c  = bus.c_req && bus.x_req;
    assign starve_inc_c = (state_q == ARB) && contested_c && c_gnt_c;

    starve_counter #(
        .W     (SCW),
        .LIMIT (STARVE_LIMIT)
    ) u_starve_counter (
        .clk   (clk),
        .reset (reset),
        .clr_i (x_gnt_c),
        .inc_i (starve_inc_c),
        .cnt_o (starve_cnt)
    );

    // External wins the contest once the core has won LIMIT in a row
    assign force_x_c = contested_c && (starve_cnt == SCW'(STARVE_LIMIT));
`else
    // Strict core priority; the limit only matters with the guard built in
    assign force_x_c = 1'b0 & (STARVE_LIMIT == 0);
`endif

    // Arbitration FSM: grants and next state
    always_comb begin
        state_d = state_q;
        c_gnt_c = 1'b0;
        x_gnt_c = 1'b0;
        case (state_q)
            ARB: begin
                if (force_x_c) begin
                    x_gnt_c = 1'b1;
                end else begin
                    c_gnt_c = bus.c_req;
                    x_gnt_c = bus.x_req && !bus.c_req;
                end
                // An external grant with lock raised claims the memory
                if (bus.x_lock && x_gnt_c) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                x_gnt_c = bus.x_req;
                if (!bus.x_lock) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
        if (reset) begin
            c_gnt_c = 1'b0;
            x_gnt_c = 1'b0;
            state_d = ARB;
        end
    end

    // Memory drive from the granted requester, zero when idle
    always_comb begin
        m_we_c    = 1'b0;
        m_addr_c  = '0;
        m_wdata_c = '0;
        if (c_gnt_c) begin
            m_we_c    = bus.c_we;
            m_addr_c  = bus.c_addr;
            m_wdata_c = bus.c_wdata;
        end else if (x_gnt_c) begin
            m_we_c    = bus.x_we;
            m_addr_c  = bus.x_addr;
            m_wdata_c = bus.x_wdata;
        end
    end

    // Read tag for the one-cycle memory latency
    always_comb begin
        rd_pend_d  = (c_gnt_c || x_gnt_c) && !m_we_c;
        rd_owner_d = x_gnt_c ? OWN_EXT : OWN_CORE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= OWN_CORE;
        end else begin
            state_q    <= state_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign bus.c_gnt      = c_gnt_c;
    assign bus.x_gnt      = x_gnt_c;
    assign bus.m_en       = c_gnt_c || x_gnt_c;
    assign bus.m_we       = m_we_c;
    assign bus.m_addr     = m_addr_c;
    assign bus.m_wdata    = m_wdata_c;
    // A return pending across a reset edge is dropped
    assign bus.c_rvalid   = rd_pend_q && (rd_owner_q == OWN_CORE) && !reset;
    assign bus.x_rvalid   = rd_pend_q && (rd_owner_q == OWN_EXT) && !reset;
    assign bus.c_rdata    = bus.m_rdata;
    assign bus.x_rdata    = bus.m_rdata;
    assign bus.core_stall = bus.c_req && !c_gnt_c && !reset;

endmodule
